// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: merges N valid/ready streams into one registered output
// stage. Arbitration is round-robin per packet, so a source that wins keeps
// the stage until its last beat has been accepted.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   UNLOCKED | between packets; round-robin search starting at ptr
//   LOCKED   | mid-packet; only owner may be granted, all others blocked
module bus_rr_arbiter #(
   parameter int Width = 8,
   parameter int N     = 4,
   parameter int IdW   = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         valid_i,
   input  logic [N-1:0]         last_i,
   input  logic [N*Width-1:0]   data_i,
   output logic [N-1:0]         ready_o,
   output logic                 valid_o,
   output logic                 last_o,
   output logic [Width-1:0]     data_o,
   output logic [IdW-1:0]       src_o,
   input  logic                 ready_i
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

   lock_e            state_q;
   lock_e            state_d;
   logic [IdW-1:0]   ptr_q;
   logic [IdW-1:0]   owner_q;
   logic [IdW-1:0]   sel;
   logic [IdW:0]     idx;
   logic             win;
   logic             load;
   logic             grant;
   logic             acc;
   logic             sel_last;
   logic [IdW-1:0]   ptr_nxt;
   logic [Width-1:0] data_a [N];

   for (genvar k = 0; k < N; k++) begin : g_unpack
      assign data_a[k] = data_i[k*Width +: Width];
   end

   // Winner selection: owner while locked, else first valid index from ptr.
   // The loop runs from the far end so the nearest valid index is written last.
   always_comb begin
      sel = '0;
      win = 1'b0;
      idx = '0;
      if (state_q == LOCKED) begin
         sel = owner_q;
         win = valid_i[owner_q];
      end else begin
         for (int i = N-1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + (IdW+1)'(i);
            if (idx >= (IdW+1)'(N)) idx = idx - (IdW+1)'(N);
            if (valid_i[idx[IdW-1:0]]) begin
               sel = idx[IdW-1:0];
               win = 1'b1;
            end
         end
      end
   end

   // Grant is suppressed during reset so no source sees a handshake that the
   // stage will not actually take.
   assign load     = ready_i | ~valid_o;
   assign grant    = rst_n & load & win;
   assign ready_o  = grant ? (N'(1) << sel) : '0;
   assign acc      = |(valid_i & ready_o);
   assign sel_last = last_i[sel];
   assign ptr_nxt  = (sel == IdW'(N-1)) ? '0 : sel + IdW'(1);

   // Lock FSM next-state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         UNLOCKED: if (acc && !sel_last) state_d = LOCKED;
         LOCKED:   if (acc && sel_last)  state_d = UNLOCKED;
         default:  state_d = UNLOCKED;
      endcase
   end

   // Lock FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= UNLOCKED;
      else        state_q <= state_d;
   end

   // Round-robin pointer advances past a source once its packet completes;
   // owner is captured on the first beat of a multi-beat packet.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         owner_q <= '0;
      end else if (acc) begin
         if (sel_last) ptr_q <= ptr_nxt;
         if (state_q == UNLOCKED && !sel_last) owner_q <= sel;
      end
   end

   // Output stage: load on accept, drain when taken with nothing new, else hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         data_o  <= '0;
         src_o   <= '0;
      end else if (acc) begin
         valid_o <= 1'b1;
         last_o  <= sel_last;
         data_o  <= data_a[sel];
         src_o   <= sel;
      end else if (load) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with N=4, Width=8.
module tb_bus_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] valid_i;
   logic [3:0] last_i;
   logic [7:0] d [4];
   logic [31:0] data_i;
   logic [3:0] ready_o;
   logic       valid_o;
   logic       last_o;
   logic [7:0] data_o;
   logic [1:0] src_o;
   logic       ready_i;

   int checks   = 0;
   int failures = 0;

   assign data_i = {d[3], d[2], d[1], d[0]};

   always #5 clk = ~clk;

   bus_rr_arbiter #(.Width(8), .N(4)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .last_i(last_i),
      .data_i(data_i), .ready_o(ready_o), .valid_o(valid_o), .last_o(last_o),
      .data_o(data_o), .src_o(src_o), .ready_i(ready_i)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      valid_i = 4'b0000;
      last_i  = 4'b1111;
      ready_i = 1'b1;
      for (int k = 0; k < 4; k++) d[k] = 8'hA0 + 8'(k);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      valid_i = 4'b1111;
      last_i  = 4'b1111;
      ready_i = 1'b1;
      for (int k = 0; k < 4; k++) d[k] = 8'hA0 + 8'(k);
      tick();
      tick();
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
      checks++; if (ready_o !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", ready_o); end
      checks++; if (src_o !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", src_o); end
      checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_o); end
      rst_n = 1'b1;
      #1;
      checks++; if (ready_o !== 4'b0001) begin failures++; $display("FAIL reset_first_ready got=%b exp=0001", ready_o); end
      tick();
      checks++; if (valid_o !== 1'b1 || src_o !== 2'd0 || data_o !== 8'hA0) begin
         failures++; $display("FAIL reset_first_grant got v=%b src=%0d d=%h exp v=1 src=0 d=a0", valid_o, src_o, data_o);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      valid_i = 4'b1111;
      last_i  = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if (valid_o !== 1'b1 || src_o !== 2'(c % 4) || data_o !== 8'hA0 + 8'(c % 4) || last_o !== 1'b1) begin
            failures++;
            $display("FAIL fairness_%0d got v=%b src=%0d d=%h exp v=1 src=%0d d=%h", c, valid_o, src_o, data_o, c % 4, 8'hA0 + 8'(c % 4));
         end
      end
   endtask

   task automatic test_packet_lock();
      logic [1:0] exp_src  [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
      logic       exp_last [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       l2       [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0] d2       [7] = '{8'h20, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h24};
      logic [7:0] exp_d    [7] = '{8'hA0, 8'hA1, 8'h21, 8'h22, 8'h23, 8'hA3, 8'hA0};
      do_reset();
      valid_i = 4'b1111;
      for (int c = 0; c < 7; c++) begin
         last_i = {1'b1, l2[c], 2'b11};
         d[2]   = d2[c];
         #1;
         if (c == 3) begin
            checks++;
            if (ready_o !== 4'b0100) begin failures++; $display("FAIL lock_ready got=%b exp=0100", ready_o); end
         end
         tick();
         checks++;
         if (src_o !== exp_src[c] || last_o !== exp_last[c] || data_o !== exp_d[c] || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL lock_beat_%0d got src=%0d l=%b d=%h v=%b exp src=%0d l=%b d=%h v=1", c, src_o, last_o, data_o, valid_o, exp_src[c], exp_last[c], exp_d[c]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      valid_i = 4'b1111;
      last_i  = 4'b1111;
      tick();
      ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (ready_o !== 4'b0000) begin failures++; $display("FAIL stall_ready_%0d got=%b exp=0000", c, ready_o); end
         tick();
         checks++;
         if (valid_o !== 1'b1 || src_o !== 2'd0 || data_o !== 8'hA0) begin
            failures++; $display("FAIL stall_hold_%0d got v=%b src=%0d d=%h exp v=1 src=0 d=a0", c, valid_o, src_o, data_o);
         end
      end
      ready_i = 1'b1;
      for (int c = 1; c < 5; c++) begin
         tick();
         checks++;
         if (valid_o !== 1'b1 || src_o !== 2'(c % 4) || data_o !== 8'hA0 + 8'(c % 4)) begin
            failures++; $display("FAIL release_%0d got src=%0d d=%h exp src=%0d d=%h", c, src_o, data_o, c % 4, 8'hA0 + 8'(c % 4));
         end
      end
   endtask

   task automatic test_owner_gap();
      do_reset();
      valid_i = 4'b0010;
      last_i  = 4'b1101;
      d[1]    = 8'h11;
      tick();
      checks++; if (src_o !== 2'd1 || valid_o !== 1'b1 || last_o !== 1'b0) begin
         failures++; $display("FAIL gap_first got src=%0d v=%b l=%b exp src=1 v=1 l=0", src_o, valid_o, last_o);
      end
      valid_i = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (ready_o !== 4'b0000) begin failures++; $display("FAIL gap_ready_%0d got=%b exp=0000", c, ready_o); end
         tick();
         checks++;
         if (valid_o !== 1'b0) begin failures++; $display("FAIL gap_valid_%0d got=%b exp=0", c, valid_o); end
      end
      valid_i = 4'b0011;
      last_i  = 4'b1111;
      d[1]    = 8'h12;
      #1;
      checks++; if (ready_o !== 4'b0010) begin failures++; $display("FAIL gap_resume_ready got=%b exp=0010", ready_o); end
      tick();
      checks++; if (src_o !== 2'd1 || valid_o !== 1'b1 || last_o !== 1'b1 || data_o !== 8'h12) begin
         failures++; $display("FAIL gap_resume got src=%0d v=%b l=%b d=%h exp src=1 v=1 l=1 d=12", src_o, valid_o, last_o, data_o);
      end
      tick();
      checks++; if (src_o !== 2'd0 || data_o !== 8'hA0) begin
         failures++; $display("FAIL gap_after got src=%0d d=%h exp src=0 d=a0", src_o, data_o);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      valid_i = 4'b1000;
      last_i  = 4'b0111;
      tick();
      tick();
      checks++; if (src_o !== 2'd3 || last_o !== 1'b0) begin
         failures++; $display("FAIL midrst_setup got src=%0d l=%b exp src=3 l=0", src_o, last_o);
      end
      valid_i = 4'b1001;
      last_i  = 4'b1111;
      rst_n   = 1'b0;
      tick();
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", valid_o); end
      rst_n = 1'b1;
      #1;
      checks++; if (ready_o !== 4'b0001) begin failures++; $display("FAIL midrst_ready got=%b exp=0001", ready_o); end
      tick();
      checks++; if (src_o !== 2'd0 || valid_o !== 1'b1) begin
         failures++; $display("FAIL midrst_grant got src=%0d v=%b exp src=0 v=1", src_o, valid_o);
      end
      tick();
      checks++; if (src_o !== 2'd3) begin failures++; $display("FAIL midrst_next got src=%0d exp=3", src_o); end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_packet_lock();
      test_backpressure();
      test_owner_gap();
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
